// File: rtl/lt100_uart_if.sv
// lt100 system bus port for the UART peripheral.
// The CPU side drives enable/wr_en/addr/i_data/be; the UART answers.
interface lt100_uart_if;
  logic        enable;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] i_data;
  logic [3:0]  be;
  logic        ready;
  logic [31:0] o_data;
  logic        bus_err;

  modport master (
    output enable, wr_en, addr, i_data, be,
    input  ready, o_data, bus_err
  );

  modport slave (
    input  enable, wr_en, addr, i_data, be,
    output ready, o_data, bus_err
  );
endinterface

// File: rtl/lt100_uart.sv
// lt100 UART: RX FIFO, single-byte TX shifter,
// runtime baud divisor and level RX interrupt.
module lt100_uart #(
  parameter int CLKS_PER_BIT    = 234,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic         clk,
  input  logic         rst,
  lt100_uart_if.slave  bus,
  output logic         irq,
  input  logic         rx_pin,
  output logic         tx_pin
);

  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    B_IDLE, B_ACCESS, B_DONE
  } bus_st_t;

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_st_t;

  bus_st_t bst, bst_nxt;
  rx_st_t  rst_q, rst_nxt;

  logic [15:0]   div;
  logic          irq_en;
  logic          overrun;
  logic          framing;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] rx_count;
  logic          nonempty;
  logic          full;

  logic          rx_meta, rx_s, rx_prev;
  logic [15:0]   rx_cnt;
  logic [15:0]   rx_div;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_push;
  logic          rx_fall, rx_half, rx_end;
  logic          frm_evt;

  logic          tx_busy;
  logic [8:0]    tx_sh;
  logic [15:0]   tx_cnt;
  logic [15:0]   tx_div;
  logic [3:0]    tx_bits;

  logic          acc, aligned;
  logic          sel_data, sel_stat;
  logic          sel_ctrl, sel_div;
  logic          do_pop, tx_load;
  logic          ctrl_wr, div_wr;
  logic          push_ok, ovf_evt;
  logic [31:0]   rdata;
  logic          unused_ok;

  assign unused_ok = ^{bus.addr[31:4],
                       bus.i_data[31:16],
                       bus.be[3:1]};

  // Bus access FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bst <= B_IDLE;
    else     bst <= bst_nxt;
  end

  always_comb begin
    bst_nxt = bst;
    unique case (bst)
      B_IDLE:   if (bus.enable) bst_nxt = B_ACCESS;
      B_ACCESS: bst_nxt = B_DONE;
      B_DONE:   if (!bus.enable) bst_nxt = B_IDLE;
      default:  bst_nxt = B_IDLE;
    endcase
  end

  assign acc      = (bst == B_ACCESS);
  assign aligned  = (bus.addr[1:0] == 2'b00);
  assign sel_data = (bus.addr[3:2] == 2'd0);
  assign sel_stat = (bus.addr[3:2] == 2'd1);
  assign sel_ctrl = (bus.addr[3:2] == 2'd2);
  assign sel_div  = (bus.addr[3:2] == 2'd3);

  assign nonempty = (rx_count != '0);
  assign full     = (rx_count == CW'(DEPTH));

  assign do_pop  = acc & aligned & ~bus.wr_en
                 & sel_data & nonempty;
  assign tx_load = acc & aligned & bus.wr_en
                 & sel_data & bus.be[0] & ~tx_busy;
  assign ctrl_wr = acc & aligned & bus.wr_en & sel_ctrl;
  assign div_wr  = acc & aligned & bus.wr_en & sel_div;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_data:
        if (nonempty) rdata = {23'b0, 1'b1, mem[rd_ptr]};
      sel_stat:
        rdata = {23'b0, 5'(rx_count), framing,
                 overrun, tx_busy, nonempty};
      sel_ctrl: rdata = {31'b0, irq_en};
      sel_div:  rdata = {16'b0, div};
      default:  rdata = '0;
    endcase
  end

  // ready trails DONE by a cycle and falls once enable is seen low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ready   <= 1'b0;
      bus.o_data  <= '0;
      bus.bus_err <= 1'b0;
    end else begin
      bus.ready <= (bst == B_DONE) & bus.enable;
      if (acc) begin
        bus.bus_err <= ~aligned;
        bus.o_data  <= (aligned && !bus.wr_en) ? rdata : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div     <= 16'(CLKS_PER_BIT);
      irq_en  <= 1'b0;
      overrun <= 1'b0;
      framing <= 1'b0;
      irq     <= 1'b0;
    end else begin
      irq <= irq_en & nonempty;
      if (div_wr)
        div <= (bus.i_data[15:0] < 16'd4) ?
               16'd4 : bus.i_data[15:0];
      if (ctrl_wr) irq_en <= bus.i_data[0];
      if (ovf_evt)
        overrun <= 1'b1;
      else if (ctrl_wr && bus.i_data[2])
        overrun <= 1'b0;
      if (frm_evt)
        framing <= 1'b1;
      else if (ctrl_wr && bus.i_data[3])
        framing <= 1'b0;
    end
  end

  // A pop in the same cycle frees the slot even when full
  assign push_ok = rx_push & (~full | do_pop);
  assign ovf_evt = rx_push & full & ~do_pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_sh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      rx_count <= rx_count + CW'(push_ok) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_pin;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign rx_fall = rx_prev & ~rx_s;
  assign rx_half = (rx_cnt == (rx_div >> 1));
  assign rx_end  = (rx_cnt == rx_div - 16'd1);
  assign frm_evt = (rst_q == R_STOP) & rx_end & ~rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_q <= R_IDLE;
    else     rst_q <= rst_nxt;
  end

  always_comb begin
    rst_nxt = rst_q;
    unique case (rst_q)
      R_IDLE:
        if (rx_fall) rst_nxt = R_START;
      R_START:
        if (rx_half) rst_nxt = rx_s ? R_IDLE : R_DATA;
      R_DATA:
        if (rx_end && rx_bit == 3'd7) rst_nxt = R_STOP;
      R_STOP:
        if (rx_end) rst_nxt = R_IDLE;
      default: rst_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt  <= '0;
      rx_div  <= 16'(CLKS_PER_BIT);
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_push <= 1'b0;
    end else begin
      rx_push <= (rst_q == R_STOP) & rx_end & rx_s;
      unique case (rst_q)
        R_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_div <= div;
        end
        R_START:
          if (rx_half) begin
            rx_cnt <= '0;
            rx_div <= div;
          end else rx_cnt <= rx_cnt + 16'd1;
        R_DATA:
          if (rx_end) begin
            rx_cnt <= '0;
            rx_div <= div;
            rx_sh  <= {rx_s, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt + 16'd1;
        R_STOP:
          if (rx_end) rx_cnt <= '0;
          else        rx_cnt <= rx_cnt + 16'd1;
        default: rx_cnt <= '0;
      endcase
    end
  end

  // tx_sh holds data then the stop bit; start is driven on load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_pin  <= 1'b1;
      tx_busy <= 1'b0;
      tx_sh   <= '0;
      tx_cnt  <= '0;
      tx_bits <= '0;
      tx_div  <= 16'(CLKS_PER_BIT);
    end else if (tx_load) begin
      tx_pin  <= 1'b0;
      tx_busy <= 1'b1;
      tx_sh   <= {1'b1, bus.i_data[7:0]};
      tx_cnt  <= '0;
      tx_bits <= '0;
      tx_div  <= div;
    end else if (tx_busy) begin
      if (tx_cnt == tx_div - 16'd1) begin
        tx_cnt <= '0;
        tx_div <= div;
        if (tx_bits == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          tx_pin  <= tx_sh[0];
          tx_sh   <= {1'b1, tx_sh[8:1]};
          tx_bits <= tx_bits + 4'd1;
        end
      end else tx_cnt <= tx_cnt + 16'd1;
    end
  end

endmodule
